// File: rtl/andchain_trace_pkg.sv
// Shared types and sizing helpers for the AndChain trace capture block.
// Define TRACE_TIMESTAMP_EN to prepend a timestamp field to every trace entry.
package andchain_trace_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain
  } state_e;

  localparam int unsigned DefaultLanes = 5;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  // Entry layout is {[ts], f, e, d} with d in the LSBs.
  function automatic int unsigned entry_w(int unsigned lanes, int unsigned ts_w);
    return 3 * lanes + (TsEn ? ts_w : 32'd0);
  endfunction

endpackage

// File: rtl/andchain_trace_capture_if.sv
// Valid/ready trace stream from the capture block to the mining/trace sink.
interface andchain_trace_capture_if #(
  parameter int unsigned Width = andchain_trace_pkg::entry_w(andchain_trace_pkg::DefaultLanes, 16)
) ();

  logic [Width-1:0] trace_data;
  logic             trace_valid;
  logic             trace_ready;

  modport master (
    output trace_data,
    output trace_valid,
    input  trace_ready
  );

  modport slave (
    input  trace_data,
    input  trace_valid,
    output trace_ready
  );

endinterface

// File: rtl/andchain_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data always shows the oldest entry.
module andchain_trace_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/andchain_trace_capture.sv
// Samples AndChain lane d/e/f outputs and queues change-compressed trace entries.
// Define TRACE_TIMESTAMP_EN to tag each entry with cycles since capture start.
module andchain_trace_capture
  import andchain_trace_pkg::*;
#(
  parameter int unsigned LANES  = DefaultLanes,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [LANES-1:0]         d_in,
  input  logic [LANES-1:0]         e_in,
  input  logic [LANES-1:0]         f_in,
  andchain_trace_capture_if.master trace,
  output logic                     busy,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned EntryW = entry_w(LANES, TS_W);
  localparam int unsigned SampW  = 3 * LANES;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [SampW-1:0]    samp_q, samp_d;
  logic [SampW-1:0]    last_q, last_d;
  logic                last_vld_q, last_vld_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_q, ts_d;
`endif

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]   push_entry, pop_entry;
  logic [CntW-1:0]     fifo_count;

`ifdef TRACE_TIMESTAMP_EN
  assign push_entry = {ts_q, samp_q};
`else
  assign push_entry = samp_q;
`endif

  always_comb begin
    samp_d     = {f_in, e_in, d_in};
    state_d    = state_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
    ts_d       = ts_q;
`endif

    // A dropped sample still becomes the reference so later repeats stay compressed.
    if (state_q == StCapture && (!last_vld_q || samp_q != last_q)) begin
      last_d     = samp_q;
      last_vld_d = 1'b1;
      if (fifo_full) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != {DROP_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end else begin
        fifo_push = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCapture;
          overflow_d = 1'b0;
          drop_cnt_d = '0;
          last_vld_d = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
          ts_d       = '0;
`endif
        end
      end
      StCapture: begin
`ifdef TRACE_TIMESTAMP_EN
        ts_d = ts_q + TS_W'(1);
`endif
        if (stop) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_count == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      samp_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  andchain_trace_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign trace.trace_valid = !fifo_empty;
  assign trace.trace_data  = pop_entry;
  assign fifo_pop          = !fifo_empty && trace.trace_ready;
  assign busy              = (state_q != StIdle);
  assign overflow          = overflow_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_andchain_trace_capture.sv
// Directed bench for andchain_trace_capture: queue-based reference model plus literal checks.
module tb_andchain_trace_capture;
  import andchain_trace_pkg::*;

  localparam int unsigned LANES  = 5;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TS_W   = 4;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned EW     = entry_w(LANES, TS_W);
  localparam int unsigned SW     = 3 * LANES;

  logic              clk = 1'b0;
  logic              rst, start, stop;
  logic [LANES-1:0]  d_in, e_in, f_in;
  logic              busy, overflow;
  logic [DROP_W-1:0] drop_cnt;

  andchain_trace_capture_if #(.Width(EW)) trace_if ();

  andchain_trace_capture #(
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .d_in     (d_in),
    .e_in     (e_in),
    .f_in     (f_in),
    .trace    (trace_if),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending entries plus the capture-mode bookkeeping.
  logic [EW-1:0]   mq[$];
  int              m_mode = 0;  // 0 idle, 1 capturing, 2 draining
  logic [SW-1:0]   m_pipe = '0;
  logic [SW-1:0]   m_last = '0;
  bit              m_last_v = 0;
  bit              m_ovf = 0;
  int              m_drops = 0;
  logic [TS_W-1:0] m_ts = '0;
  int              m_xfers = 0;

  always @(posedge clk) begin
    int pre_n;
    pre_n = mq.size();
    if (rst) begin
      mq.delete();
      m_mode   = 0;
      m_last_v = 0;
      m_ovf    = 0;
      m_drops  = 0;
      m_ts     = '0;
      m_pipe   = '0;
    end else begin
      if (pre_n > 0 && trace_if.trace_ready) begin
        void'(mq.pop_front());
        m_xfers++;
      end
      if (m_mode == 1 && (!m_last_v || m_pipe != m_last)) begin
        m_last   = m_pipe;
        m_last_v = 1;
        if (pre_n == DEPTH) begin
          m_ovf = 1;
          if (m_drops < (1 << DROP_W) - 1) m_drops++;
        end else begin
`ifdef TRACE_TIMESTAMP_EN
          mq.push_back({m_ts, m_pipe});
`else
          mq.push_back(m_pipe);
`endif
        end
      end
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_ovf = 0; m_drops = 0; m_last_v = 0; m_ts = '0;
        end
        1: begin
          m_ts++;
          if (stop) m_mode = 2;
        end
        default: if (pre_n == 0) m_mode = 0;
      endcase
      m_pipe = {f_in, e_in, d_in};
    end
  end

  // Per-cycle comparison against the model, 1 time unit after the active edge.
  bit            cmp_en = 0;
  logic          last_v = 1'b0;
  logic          last_r = 1'b0;
  logic [EW-1:0] last_d = '0;

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("valid", trace_if.trace_valid, mq.size() != 0);
      if (mq.size() != 0) check("data", trace_if.trace_data, mq[0]);
      check("busy", busy, m_mode != 0);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drops);
      if (!rst && last_v && !last_r)
        check("hold", {trace_if.trace_valid, trace_if.trace_data}, {1'b1, last_d});
    end
    last_v = trace_if.trace_valid;
    last_d = trace_if.trace_data;
  end

  always @(negedge clk) begin
    #1;
    last_r = trace_if.trace_ready;
  end

  task automatic set_lanes(input logic [SW-1:0] v);
    {f_in, e_in, d_in} = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [SW-1:0] exp);
    check({name, "_valid"}, trace_if.trace_valid, 1'b1);
    check({name, "_data"}, trace_if.trace_data[SW-1:0], exp);
    trace_if.trace_ready = 1'b1;
    @(negedge clk);
    trace_if.trace_ready = 1'b0;
  endtask

  task automatic finish_capture(input string name);
    int n;
    n = 0;
    trace_if.trace_ready = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [SW-1:0] vals [8];
    vals = '{15'h0001, 15'h0022, 15'h0403, 15'h7fff, 15'h0000, 15'h1234, 15'h0a0a, 15'h5555};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_lanes('0);
    trace_if.trace_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;
    check("rst_valid", trace_if.trace_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, '0);

    // 1: constant input gives exactly one entry, visible after the second edge.
    base = m_xfers;
    set_lanes(15'h0001);
    trace_if.trace_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_not_yet", trace_if.trace_valid, 1'b0);
    @(negedge clk);
    check("t1_valid", trace_if.trace_valid, 1'b1);
    check("t1_data", trace_if.trace_data[SW-1:0], 15'h0001);
    repeat (9) @(negedge clk);
    check("t1_one_entry", m_xfers - base, 1);
    check("t1_empty", trace_if.trace_valid, 1'b0);
    finish_capture("t1_idle");

    // 2: 40 changes into a 16-deep FIFO with the sink stalled.
    do_reset();
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_lanes((i % 2 == 0) ? 15'h0001 : 15'h0000);
      start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_overflow", overflow, 1'b1);
    check("t2_drop_cnt", drop_cnt, 8'd24);
    for (int k = 0; k < 16; k++)
      pop_expect("t2_pop", (k % 2 == 0) ? 15'h0001 : 15'h0000);
    check("t2_drained", trace_if.trace_valid, 1'b0);
    finish_capture("t2_idle");

    // 3: random backpressure over 8 distinct samples.
    do_reset();
    base = m_xfers;
    for (int i = 0; i < 8; i++) begin
      set_lanes(vals[i]);
      if (i == 0) start = 1'b1;
      repeat (3) begin
        trace_if.trace_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
      end
    end
    n = 0;
    while (trace_if.trace_valid && n < 100) begin
      trace_if.trace_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("t3_transfers", m_xfers - base, 8);
    finish_capture("t3_idle");

    // 4: stop with three entries queued; start during drain is ignored.
    do_reset();
    trace_if.trace_ready = 1'b0;
    set_lanes(15'h0011); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_lanes(15'h0022);
    @(negedge clk);
    set_lanes(15'h0033);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_busy_draining", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pop_expect("t4_pop0", 15'h0011);
    pop_expect("t4_pop1", 15'h0022);
    check("t4_busy_mid", busy, 1'b1);
    pop_expect("t4_pop2", 15'h0033);
    @(negedge clk);
    check("t4_idle", busy, 1'b0);
    set_lanes(15'h0044);
    repeat (3) @(negedge clk);
    check("t4_still_idle", busy, 1'b0);
    check("t4_no_entry", trace_if.trace_valid, 1'b0);

    // 5: reset while capturing with five entries pending.
    do_reset();
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lanes(SW'(i + 1));
      start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    check("t5_pending", trace_if.trace_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_valid", trace_if.trace_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_overflow", overflow, 1'b0);
    check("t5_drop_cnt", drop_cnt, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef TRACE_TIMESTAMP_EN
    // 6: timestamps at capture cycles 0, 3, 7 and a wrap at cycle 16.
    do_reset();
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_lanes((i < 3) ? 15'h0001 : (i < 7) ? 15'h0002 : (i < 16) ? 15'h0003 : 15'h0004);
      start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    check("t6_ts0", trace_if.trace_data[EW-1:SW], 4'd0);
    pop_expect("t6_e0", 15'h0001);
    check("t6_ts3", trace_if.trace_data[EW-1:SW], 4'd3);
    pop_expect("t6_e1", 15'h0002);
    check("t6_ts7", trace_if.trace_data[EW-1:SW], 4'd7);
    pop_expect("t6_e2", 15'h0003);
    check("t6_ts_wrap", trace_if.trace_data[EW-1:SW], 4'd0);
    pop_expect("t6_e3", 15'h0004);
    finish_capture("t6_idle");
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
